// File: rtl/heichips25_nibble_mem_responder.sv
// rtl/heichips25_nibble_mem_responder.sv - nibble-serialized memory bus responder to a sync-read SRAM port
// Optional HEICHIPS25_RSP_WRITE_ACK_EN: one response beat acknowledges each SRAM write.
module heichips25_nibble_mem_responder #(
    parameter int AddrWidth = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [AddrWidth-1:0] req_addr_i,
    input  logic                 req_write_i,
    input  logic                 req_strb_i,
    input  logic [3:0]           req_nibble_i,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    output logic [3:0]           rsp_nibble_o,
    output logic                 rsp_last_o,
    output logic                 rsp_valid_o,
    input  logic                 rsp_ready_i,
    output logic                 mem_req_o,
    output logic                 mem_we_o,
    output logic [AddrWidth-1:0] mem_addr_o,
    output logic [3:0]           mem_be_o,
    output logic [31:0]          mem_wdata_o,
    input  logic [31:0]          mem_rdata_i
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_COLLECT,
        S_WR_ISSUE,
        S_RD_ISSUE,
        S_RD_CAPTURE,
`ifdef HEICHIPS25_RSP_WRITE_ACK_EN
        S_WR_ACK,
`endif
        S_RSP_SEND
    } state_e;

    state_e               state_q, state_d;
    logic [2:0]           cnt_q;
    logic [AddrWidth-1:0] addr_q;
    logic [31:0]          wdata_q;
    logic [7:0]           strb_q;
    logic [31:0]          shreg_q;

    assign mem_addr_o = addr_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        req_ready_o  = 1'b0;
        rsp_valid_o  = 1'b0;
        rsp_last_o   = 1'b0;
        rsp_nibble_o = 4'h0;
        mem_req_o    = 1'b0;
        mem_we_o     = 1'b0;
        mem_be_o     = 4'h0;
        mem_wdata_o  = 32'h0;
        case (state_q)
            S_IDLE: begin
                req_ready_o = 1'b1;
                if (req_valid_i) begin
                    state_d = req_write_i ? S_WR_COLLECT : S_RD_ISSUE;
                end
            end
            S_WR_COLLECT: begin
                req_ready_o = 1'b1;
                if (req_valid_i && cnt_q == 3'd7) begin
                    state_d = S_WR_ISSUE;
                end
            end
            S_WR_ISSUE: begin
                mem_req_o   = 1'b1;
                mem_we_o    = 1'b1;
                // a byte is enabled when either of its nibbles was strobed
                mem_be_o    = {strb_q[7] | strb_q[6], strb_q[5] | strb_q[4],
                               strb_q[3] | strb_q[2], strb_q[1] | strb_q[0]};
                mem_wdata_o = wdata_q;
`ifdef HEICHIPS25_RSP_WRITE_ACK_EN
                state_d     = S_WR_ACK;
`else
                state_d     = S_IDLE;
`endif
            end
            S_RD_ISSUE: begin
                mem_req_o = 1'b1;
                mem_be_o  = 4'hF;
                state_d   = S_RD_CAPTURE;
            end
            S_RD_CAPTURE: begin
                state_d = S_RSP_SEND;
            end
            S_RSP_SEND: begin
                rsp_valid_o  = 1'b1;
                rsp_nibble_o = shreg_q[3:0];
                rsp_last_o   = (cnt_q == 3'd7);
                if (rsp_ready_i && cnt_q == 3'd7) begin
                    state_d = S_IDLE;
                end
            end
`ifdef HEICHIPS25_RSP_WRITE_ACK_EN
            S_WR_ACK: begin
                rsp_valid_o = 1'b1;
                rsp_last_o  = 1'b1;
                if (rsp_ready_i) begin
                    state_d = S_IDLE;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q   <= 3'd0;
            addr_q  <= '0;
            wdata_q <= 32'h0;
            strb_q  <= 8'h0;
            shreg_q <= 32'h0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req_valid_i) begin
                        addr_q <= req_addr_i;
                        if (req_write_i) begin
                            wdata_q[3:0] <= req_nibble_i;
                            strb_q[0]    <= req_strb_i;
                            cnt_q        <= 3'd1;
                        end
                    end
                end
                S_WR_COLLECT: begin
                    // cnt wraps 7 -> 0 on the final beat
                    if (req_valid_i) begin
                        wdata_q[{cnt_q, 2'b00} +: 4] <= req_nibble_i;
                        strb_q[cnt_q]                <= req_strb_i;
                        cnt_q                        <= cnt_q + 3'd1;
                    end
                end
                S_RD_CAPTURE: begin
                    shreg_q <= mem_rdata_i;
                    cnt_q   <= 3'd0;
                end
                S_RSP_SEND: begin
                    if (rsp_ready_i) begin
                        shreg_q <= {4'h0, shreg_q[31:4]};
                        cnt_q   <= cnt_q + 3'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
